// File: rtl/register_file.sv
// register_file: 16 x WIDTH general-purpose register file with a one-hot write
// strobe, two registered read ports, a written-since-reset mask and a sticky
// multi-hot strobe error flag.
// Optional feature: define REGFILE_BYPASS_EN to forward same-edge write data
// to a read port addressing the register being written. Without it, a
// colliding read returns the old contents.
module register_file #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,       // asynchronous, active-low
  input  logic [15:0]      regEnable,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  input  logic [3:0]       raddr_a,
  input  logic [3:0]       raddr_b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic [15:0]      valid_mask,
  output logic             onehot_err
);

  logic [WIDTH-1:0] regs_q [16];
  logic [WIDTH-1:0] regs_d [16];
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic [15:0]      valid_q, valid_d;
  logic             err_q, err_d;

  // x & (x-1) clears the lowest set bit; anything left means two or more bits.
  logic multi_hot;
  logic legal_wr;
  assign multi_hot = |(regEnable & (regEnable - 16'd1));
  assign legal_wr  = (|regEnable) && !multi_hot;

  // Read-port source: array contents, optionally overridden by same-edge write data.
  function automatic logic [WIDTH-1:0] read_sel(input logic [3:0] addr);
    logic [WIDTH-1:0] val;
    val = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
    if (legal_wr && regEnable[addr]) val = wdata;
`endif
    return val;
  endfunction

  // Next-state for storage, valid mask, error flag and read ports.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    regs_d    = regs_q;
    valid_d   = valid_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    if (legal_wr) begin
      for (int i = 0; i < 16; i++) begin
        if (regEnable[i]) regs_d[i] = wdata;
      end
      valid_d = valid_q | regEnable;
    end
    // A new illegal strobe wins over a same-edge clear.
    err_d = multi_hot | (err_q & ~err_clr);
    if (rd_en) begin
      rdata_a_d = read_sel(raddr_a);
      rdata_b_d = read_sel(raddr_b);
    end
  end

  // State registers; reset clears the whole array so no stale data survives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the storage array is reset deliberately: a read after reset must
      // return zero, so this cannot be left to a reset-less RAM macro.
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      valid_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      regs_q    <= regs_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign rdata_a    = rdata_a_q;
  assign rdata_b    = rdata_b_q;
  assign valid_mask = valid_q;
  assign onehot_err = err_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file. Read data is checked through a
// scoreboard queue; status outputs are checked directly by the stimulus.
module tb_register_file;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [15:0]      regEnable;
  logic [WIDTH-1:0] wdata;
  logic             rd_en;
  logic [3:0]       raddr_a;
  logic [3:0]       raddr_b;
  logic             err_clr;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic [15:0]      valid_mask;
  logic             onehot_err;

  int checks   = 0;
  int failures = 0;

  // Expected {rdata_a, rdata_b} for each issued read, oldest first.
  logic [31:0] sb_q[$];
  logic        rd_pending = 1'b0;

  register_file #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .regEnable  (regEnable),
    .wdata      (wdata),
    .rd_en      (rd_en),
    .raddr_a    (raddr_a),
    .raddr_b    (raddr_b),
    .err_clr    (err_clr),
    .rdata_a    (rdata_a),
    .rdata_b    (rdata_b),
    .valid_mask (valid_mask),
    .onehot_err (onehot_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a read edge (rd_en high, out of reset) produces new read data.
  always @(posedge clk) rd_pending <= rd_en && reset;

  always @(negedge clk) begin
    if (rd_pending) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        logic [31:0] exp;
        exp = sb_q.pop_front();
        check("rdata_a", {16'h0, rdata_a}, {16'h0, exp[31:16]});
        check("rdata_b", {16'h0, rdata_b}, {16'h0, exp[15:0]});
      end
    end
  end

  // Stimulus tasks start just after a falling edge and end on the next one.
  task automatic wr(input logic [15:0] en, input logic [15:0] d);
    regEnable = en;
    wdata     = d;
    @(negedge clk);
    regEnable = '0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] b,
                    input logic [15:0] ea, input logic [15:0] eb);
    raddr_a = a;
    raddr_b = b;
    rd_en   = 1'b1;
    sb_q.push_back({ea, eb});
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    regEnable = '0;
    wdata     = '0;
    rd_en     = 1'b0;
    raddr_a   = '0;
    raddr_b   = '0;
    err_clr   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid_mask", {16'h0, valid_mask}, 32'h0);
    check("rst_onehot_err", {31'h0, onehot_err}, 32'h0);
    check("rst_rdata_a", {16'h0, rdata_a}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Write every register, then read them all back on both ports.
    for (int i = 0; i < 16; i++) wr(16'h1 << i, 16'hA500 + 16'(i));
    check("all_valid_mask", {16'h0, valid_mask}, 32'hFFFF);
    for (int i = 0; i < 16; i++)
      rd(4'(i), 4'(15 - i), 16'hA500 + 16'(i), 16'hA500 + 16'(15 - i));

    // Mid-cycle asynchronous reset with live data and a set error flag.
    wr(16'h0020, 16'hBEEF);
    rd(4'd5, 4'd5, 16'hBEEF, 16'hBEEF);
    wr(16'h0003, 16'h1111);
    check("pre_rst_err", {31'h0, onehot_err}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_rdata_a", {16'h0, rdata_a}, 32'h0);
    check("async_rst_rdata_b", {16'h0, rdata_b}, 32'h0);
    check("async_rst_valid", {16'h0, valid_mask}, 32'h0);
    check("async_rst_err", {31'h0, onehot_err}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd(4'd5, 4'd0, 16'h0000, 16'h0000);

    // Illegal multi-hot strobe.
    wr(16'h0008, 16'h1234);
    wr(16'h0080, 16'h5678);
    check("pre_illegal_valid", {16'h0, valid_mask}, 32'h0088);
    wr(16'h0088, 16'hFFFF);
    check("illegal_err_set", {31'h0, onehot_err}, 32'h1);
    check("illegal_valid", {16'h0, valid_mask}, 32'h0088);
    rd(4'd3, 4'd7, 16'h1234, 16'h5678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("err_sticky", {31'h0, onehot_err}, 32'h1);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", {31'h0, onehot_err}, 32'h0);
    err_clr = 1'b1;
    wr(16'h8001, 16'hFFFF);
    err_clr = 1'b0;
    check("err_set_wins", {31'h0, onehot_err}, 32'h1);
    rd(4'd0, 4'd15, 16'h0000, 16'h0000);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Same-edge write/read collision on r9.
    wr(16'h0200, 16'h0001);
    raddr_a   = 4'd9;
    raddr_b   = 4'd3;
    rd_en     = 1'b1;
    regEnable = 16'h0200;
    wdata     = 16'h0002;
`ifdef REGFILE_BYPASS_EN
    sb_q.push_back({16'h0002, 16'h1234});
`else
    sb_q.push_back({16'h0001, 16'h1234});
`endif
    @(negedge clk);
    rd_en     = 1'b0;
    regEnable = '0;
    rd(4'd9, 4'd9, 16'h0002, 16'h0002);

    // Hold: outputs keep their value while rd_en is low.
    wr(16'h1000, 16'hCAFE);
    rd(4'd12, 4'd7, 16'hCAFE, 16'h5678);
    for (int i = 0; i < 4; i++) begin
      raddr_a = 4'(i + 1);
      raddr_b = 4'(i);
      wr(16'h0002 << (i == 0 ? 0 : (i == 1 ? 1 : (i == 2 ? 3 : 5))), 16'h0100 + 16'(i));
      check("hold_rdata_a", {16'h0, rdata_a}, 32'hCAFE);
      check("hold_rdata_b", {16'h0, rdata_b}, 32'h5678);
    end
    check("hold_valid_mask", {16'h0, valid_mask}, 32'h12DE);

    // No-op writes change nothing.
    for (int i = 0; i < 3; i++) wr(16'h0000, 16'hDEAD);
    check("noop_valid_mask", {16'h0, valid_mask}, 32'h12DE);
    check("noop_err", {31'h0, onehot_err}, 32'h0);
    rd(4'd3, 4'd7, 16'h1234, 16'h5678);
    rd(4'd9, 4'd12, 16'h0002, 16'hCAFE);
    rd(4'd0, 4'd6, 16'h0000, 16'h0103);
    rd(4'd1, 4'd4, 16'h0100, 16'h0102);

    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/register_file.md
# register_file

Sixteen-entry general-purpose register file for the datapath. It sits directly downstream of `rdest_decoder` and consumes its one-hot `regEnable` vector as the write strobe. It provides two synchronous read ports feeding the ALU operand muxes. It also tracks which registers have been written since reset and flags illegal multi-hot write strobes.

## Interface
Parameters:
- `WIDTH`, 16, data width of each register and of the write/read data ports.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately on assertion.
- `regEnable` input 16: one-hot write strobe from `rdest_decoder`; all-zero means no write.
- `wdata` input WIDTH: write-back data.
- `rd_en` input 1: read-port update enable; when low, both read outputs hold.
- `raddr_a` input 4: read port A address.
- `raddr_b` input 4: read port B address.
- `err_clr` input 1: synchronous clear of `onehot_err`.
- `rdata_a` output WIDTH: registered read data, port A.
- `rdata_b` output WIDTH: registered read data, port B.
- `valid_mask` output 16: bit i is 1 once register i has been written since reset.
- `onehot_err` output 1: sticky flag; set when `regEnable` has two or more bits set.

## Operation
- Storage is 16 × WIDTH flops, `r0` to `r15`. `r0` is an ordinary writable register with no hardwiring.
- Write legality: a write is legal when `regEnable` has exactly one bit set. Zero bits set is a no-op.
- Legal write: the register selected by the set bit loads `wdata`, and the matching `valid_mask` bit sets.
- Illegal write (two or more bits set):
  - No register or `valid_mask` bit changes.
  - `onehot_err` sets on that edge.
- `onehot_err` stays set until `reset` or `err_clr`.
  - If `err_clr` and a new illegal strobe occur on the same edge, set wins and `onehot_err` stays 1.
- Reads: on each rising edge with `rd_en`=1:
  - `rdata_a` loads the selected register (`raddr_a`).
  - `rdata_b` loads the selected register (`raddr_b`).
  - Both ports may address the same register.
- With `rd_en`=0, both read outputs hold their previous value.
- Read/write collision, same edge and same address: behaviour is set by `REGFILE_BYPASS_EN` (see Configuration).
- No state machine. The block is a storage array plus three status flop groups.

## Timing
- Reset values while `reset`=0:
  - All registers: 0.
  - `rdata_a`, `rdata_b`: 0.
  - `valid_mask`: 16'h0000.
  - `onehot_err`: 0.
- Reset deassertion is asynchronous; the first write or read takes effect on the first rising edge after `reset` goes high.
- Write latency: data presented on edge N is stored at edge N.
  - A read of that address on edge N+1 returns it on `rdata` after edge N+1.
- Read latency: 1 cycle from address to `rdata`.
- `valid_mask` and `onehot_err` update on the same edge as the write attempt.
- Reset asserted mid-cycle clears everything immediately, including any in-flight write. No partial writes are permitted.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined:
  - On an edge where a legal write targets register k and a read port addresses k with `rd_en`=1, that port captures `wdata`, the new value.
  - Bypass applies independently to each port.
  - Illegal strobes never bypass.
- Undefined:
  - The read port captures the old contents of register k.
  - The new value is visible one read later.

## Test plan
- Reset check: assert `reset`=0 mid-run after writing `r5`=16'hBEEF. Required response, without waiting for an edge:
  - All `rdata`=0.
  - `valid_mask`=0.
  - `onehot_err`=0.
  - A read of `r5` after release returns 0.
- Write/read all: for each i, write `regEnable`=1<<i with `wdata`=16'hA500+i, then read each i on both ports. Required response:
  - Each port returns 16'hA500+i one cycle after the read edge.
  - `valid_mask`=16'hFFFF at the end.
- Illegal strobe: `r3`=16'h1234 and `r7`=16'h5678 are preloaded, then `regEnable`=16'h0088 with `wdata`=16'hFFFF. Required response:
  - `r3`, `r7` and `valid_mask` are unchanged.
  - `onehot_err`=1 and holds through 5 idle cycles.
  - `err_clr` pulse returns it to 0.
  - Simultaneous `err_clr` with an illegal strobe leaves it at 1.
- Same-edge collision: `r9`=16'h0001 is preloaded, then write `r9`=16'h0002 with `raddr_a`=9 and `rd_en`=1 on the same edge. Required response:
  - `rdata_a`=16'h0002 with `REGFILE_BYPASS_EN` defined.
  - `rdata_a`=16'h0001 without it.
  - The next read returns 16'h0002 in both builds.
- Hold: load `rdata_a`=16'hCAFE, set `rd_en`=0, change `raddr_a` and write other registers for 4 cycles. Required response: `rdata_a` stays 16'hCAFE.
- No-op write: `regEnable`=0 with `wdata`=16'hDEAD for 3 cycles. Required response: no register, `valid_mask` or `onehot_err` change.
